// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared state encoding and default sizing for the tone period meter
package tone_pkg;

  localparam int COUNTER_BITS_DEF = 10;
  localparam int SYNC_STAGES_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    OVER
  } meter_state_t;

endpackage

// File: rtl/tone_edge_sync.sv
// rtl/tone_edge_sync.sv - synchronizer chain plus registered any-edge detector for tone_in
module tone_edge_sync
  import tone_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tone_in,
  output logic edge_pulse,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  // edge_pulse is registered so the meter sees a clean one-cycle strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= '0;
      last       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], tone_in};
      last       <= sync[SYNC_STAGES-1];
      edge_pulse <= sync[SYNC_STAGES-1] ^ last;
    end
  end

  assign level = last;

endmodule

// File: rtl/tone_period_meter.sv
// rtl/tone_period_meter.sv - half-period meter of an async tone in enable ticks; TONE_METER_STABLE_EN requires two equal readings
module tone_period_meter
  import tone_pkg::*;
#(
  parameter int COUNTER_BITS = COUNTER_BITS_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    tone_in,
  output logic [COUNTER_BITS-1:0] period,
  output logic                    valid,
  output logic                    locked,
  output logic                    overflow
);

  localparam logic [COUNTER_BITS:0] FULL = {1'b1, {COUNTER_BITS{1'b0}}};
  localparam logic [COUNTER_BITS:0] SAT  = FULL + 1'b1;

  meter_state_t          state;
  logic [COUNTER_BITS:0] cnt;
  logic [COUNTER_BITS:0] cnt_next;
  logic                  edge_pulse;
`ifdef TONE_METER_STABLE_EN
  logic [COUNTER_BITS:0] raw;
  logic                  raw_have;
`endif

  tone_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .tone_in   (tone_in),
    .edge_pulse(edge_pulse),
    .level     ()
  );

  // the tick of the edge cycle itself belongs to the interval being closed
  always_comb begin
    cnt_next = cnt;
    if (enable && cnt != SAT)
      cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      period   <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
`ifdef TONE_METER_STABLE_EN
      raw      <= '0;
      raw_have <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_pulse) begin
            state <= MEASURE;
            cnt   <= '0;
          end
        end
        MEASURE: begin
          if (edge_pulse) begin
            cnt <= '0;
            if (cnt_next != '0 && cnt_next <= FULL) begin
`ifdef TONE_METER_STABLE_EN
              if (raw_have && cnt_next == raw) begin
                period <= cnt_next[COUNTER_BITS-1:0];
                valid  <= 1'b1;
                locked <= 1'b1;
              end else begin
                locked   <= 1'b0;
                raw      <= cnt_next;
                raw_have <= 1'b1;
              end
`else
              period <= cnt_next[COUNTER_BITS-1:0];
              valid  <= 1'b1;
              locked <= 1'b1;
`endif
            end else if (cnt_next != '0) begin
              // edge landed on the saturating tick: too long to trust
              locked <= 1'b0;
            end
          end else if (cnt_next == SAT) begin
            state    <= OVER;
            cnt      <= cnt_next;
            overflow <= 1'b1;
            locked   <= 1'b0;
`ifdef TONE_METER_STABLE_EN
            raw_have <= 1'b0;
`endif
          end else begin
            cnt <= cnt_next;
          end
        end
        OVER: begin
          if (edge_pulse) begin
            state    <= MEASURE;
            cnt      <= '0;
            overflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// tb/tb_tone_period_meter.sv - scoreboard bench for tone_period_meter with an in-bench tone generator
module tb_tone_period_meter;

`ifdef TONE_METER_STABLE_EN
  localparam bit STABLE = 1'b1;
`else
  localparam bit STABLE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       man_tone = 1'b0;
  logic       gen_tone = 1'b0;
  logic       tone_in;
  logic [9:0] period;
  logic       valid;
  logic       locked;
  logic       overflow;

  logic       gen_on = 1'b0;
  logic       gen_clr = 1'b0;
  logic [9:0] gen_cmp_m1 = 10'd0;
  logic [9:0] gcnt = 10'd0;
  int         gen_toggles = 0;
  int         gen_limit = 0;

  typedef struct {
    int per;
    int lck;
    int gap;
  } exp_t;
  exp_t sbq[$];

  int  checks = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last_valid_cyc = 0;
  bit  ovf_seen = 1'b0;

  int  m_period = 0;
  int  m_locked = 0;
  int  raw = 0;
  bit  raw_have = 1'b0;
  bit  prev_acc = 1'b0;

  assign tone_in = man_tone ^ gen_tone;

  tone_period_meter #(
    .COUNTER_BITS(10),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .tone_in (tone_in),
    .period  (period),
    .valid   (valid),
    .locked  (locked),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // tone generator: toggles after every 'compare' enabled ticks (compare 0 means 1024)
  always @(posedge clk) begin
    if (gen_clr) begin
      gcnt        <= '0;
      gen_toggles <= 0;
    end else if (gen_on && enable && gen_toggles < gen_limit) begin
      if (gcnt == gen_cmp_m1) begin
        gen_tone    <= ~gen_tone;
        gcnt        <= '0;
        gen_toggles <= gen_toggles + 1;
      end else begin
        gcnt <= gcnt + 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (overflow) ovf_seen = 1'b1;
      if (valid) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid: got period %0d expected no valid", period);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("period", int'(period), e.per);
          chk("locked_with_valid", int'(locked), e.lck);
          if (e.gap != 0) chk("valid_gap", cyc - last_valid_cyc, e.gap);
        end
        last_valid_cyc = cyc;
      end
    end
  end

  task automatic model_reset();
    m_period = 0;
    m_locked = 0;
    raw_have = 1'b0;
    prev_acc = 1'b0;
  endtask

  task automatic model_over();
    m_locked = 0;
    raw_have = 1'b0;
    prev_acc = 1'b0;
  endtask

  task automatic model_close(input int c, input int gap);
    if (c == 0) return;
    if (STABLE && !(raw_have && c == raw)) begin
      raw      = c;
      raw_have = 1'b1;
      m_locked = 0;
      prev_acc = 1'b0;
      return;
    end
    m_period = c % 1024;
    m_locked = 1;
    sbq.push_back(exp_t'{m_period, 1, prev_acc ? gap : 0});
    prev_acc = 1'b1;
  endtask

  task automatic step(input bit tog, input bit en);
    @(posedge clk);
    #1;
    if (tog) man_tone = ~man_tone;
    enable = en;
  endtask

  task automatic run(input int n, input bit en);
    repeat (n) step(1'b0, en);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    enable   = 1'b0;
    gen_on   = 1'b0;
    man_tone = gen_tone;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("reset_period", int'(period), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_overflow", int'(overflow), 0);
  endtask

  task automatic check_drain(input string name);
    chk(name, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic run_gen(input int cmp, input int div, input int limit, input int budget);
    int n;
    gen_cmp_m1 = 10'(cmp - 1);
    gen_limit  = limit;
    gen_clr    = 1'b1;
    step(1'b0, 1'b0);
    gen_clr = 1'b0;
    gen_on  = 1'b1;
    n = 0;
    while (gen_toggles < limit && n < budget) begin
      @(posedge clk);
      #1;
      enable = (n % div == 0);
      n++;
    end
    if (n >= budget) begin
      checks++;
      fails++;
      $display("FAIL gen_timeout: got %0d toggles expected %0d", gen_toggles, limit);
    end
    repeat (8) begin
      @(posedge clk);
      #1;
      enable = (n % div == 0);
      n++;
    end
    gen_on = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // steady tone, compare=5, enable always high; first edge only leaves IDLE
    for (int i = 0; i < 9; i++) model_close(5, 5);
    run_gen(5, 1, 10, 200);
    chk("gen5_locked", int'(locked), m_locked);
    check_drain("gen5_drain");

    // hand-placed ticks: the tick in the closing edge cycle counts, then restart
    do_reset();
    model_close(2, 10);
    model_close(3, 10);
    for (int s = 0; s <= 30; s++)
      step(s == 0 || s == 10 || s == 20, s == 5 || (s >= 13 && s <= 16));
    chk("coincide_period", int'(period), m_period);
    check_drain("coincide_drain");

    // enable every 4th clk, compare=3
    do_reset();
    for (int i = 0; i < 4; i++) model_close(3, 12);
    run_gen(3, 4, 5, 300);
    check_drain("div4_drain");

    // intervals 7, 8, 8
    do_reset();
    model_close(7, 8);
    model_close(8, 8);
    model_close(8, 8);
    for (int s = 0; s <= 30; s++) step(s == 0 || s == 7 || s == 15 || s == 23, 1'b1);
    chk("stable_period", int'(period), m_period);
    chk("stable_locked", int'(locked), m_locked);
    check_drain("stable_drain");

    // overflow at tick 1025, recovery, then a zero-tick glitch pair
    do_reset();
    model_close(6, 6);
    model_close(6, 6);
    step(1'b1, 1'b1); run(5, 1'b1);
    step(1'b1, 1'b1); run(5, 1'b1);
    step(1'b1, 1'b1);
    run(1028, 1'b1);
    chk("ovf_tick1024", int'(overflow), 0);
    chk("lock_tick1024", int'(locked), m_locked);
    run(1, 1'b1);
    model_over();
    chk("ovf_tick1025", int'(overflow), 1);
    chk("lock_tick1025", int'(locked), 0);
    run(70, 1'b1);
    chk("ovf_held", int'(overflow), 1);
    step(1'b1, 1'b0); run(5, 1'b0);
    chk("ovf_cleared", int'(overflow), 0);
    step(1'b1, 1'b0); run(3, 1'b0);
    model_close(9, 0);
    run(5, 1'b1); step(1'b1, 1'b1); run(3, 1'b1);
    run(4, 1'b0); step(1'b1, 1'b0); run(1, 1'b0); step(1'b1, 1'b0); run(8, 1'b0);
    chk("glitch_period", int'(period), m_period);
    chk("glitch_locked", int'(locked), m_locked);
    chk("glitch_overflow", int'(overflow), 0);
    check_drain("ovf_drain");

    // compare=0: 1024-tick half-period encodes as 0 without overflow
    do_reset();
    ovf_seen = 1'b0;
    model_close(1024, 1024);
    model_close(1024, 1024);
    run_gen(0, 1, 3, 3300);
    chk("full_no_overflow", int'(ovf_seen), 0);
    chk("full_period", int'(period), m_period);
    check_drain("full_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
